// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pad-bus arbiter.
//   arb_state_e : arbiter FSM states
//   DIR_IN/OUT  : bus direction encoding (matches req_write: 1 = drive)
//   OE_ALL/NONE : pad-enable patterns
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    XFER = 2'd2
  } arb_state_e;

  localparam logic       DIR_IN   = 1'b0;
  localparam logic       DIR_OUT  = 1'b1;
  localparam logic [7:0] OE_ALL   = 8'hFF;
  localparam logic [7:0] OE_NONE  = 8'h00;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker.
//   valid   : per-requester request
//   last    : index granted most recently
//   gnt_idx : chosen requester (only meaningful when gnt_any)
//   gnt_any : at least one requester is valid
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       gnt_idx,
  output logic       gnt_any
);

  always_comb begin
    gnt_any = |valid;
    // On contention alternate away from the last winner; otherwise take the lone requester.
    if (valid == 2'b11) gnt_idx = ~last;
    else                gnt_idx = valid[1];
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Arbitrates the shared 8-bit bidirectional uio pad bus between two requesters.
// Each granted transfer holds the pins for HOLD_CYCLES; a TURN gap of TURN_CYCLES
// with the pads released is inserted whenever the pin direction changes.
//   clk, rst_n  : clock, asynchronous active-low reset
//   ena         : blocks new grants when low
//   req_valid/req_write/req_wdata : per-requester request, direction and write byte
//   req_ready   : one-cycle pulse in the last transfer cycle
//   rsp_valid/rsp_rdata           : read-data pulse and last sampled byte
//   uio_in/uio_out/uio_oe         : pad interface
//   busy        : TURN or XFER in progress
//   last_grant  : most recently granted requester
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  input  logic [7:0]  uio_in,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe,
  output logic        busy,
  output logic        last_grant
);

  localparam int unsigned MaxCyc = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] TurnLast = CntW'(TURN_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic            HoldOne  = (HOLD_CYCLES == 1);

  arb_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            dir_q;
  logic            gnt_q;
  logic            wr_q;
  logic [7:0]      byte_q;

  logic            pick_idx;
  logic            pick_any;
  logic            pick_wr;
  logic [7:0]      pick_byte;

  rr_arb2 u_rr_arb2 (
    .valid   (req_valid),
    .last    (last_grant),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  always_comb begin
    pick_wr   = req_write[pick_idx];
    pick_byte = pick_idx ? req_wdata[15:8] : req_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dir_q      <= DIR_IN;
      gnt_q      <= 1'b0;
      wr_q       <= DIR_IN;
      byte_q     <= 8'h00;
      req_ready  <= 2'b00;
      rsp_valid  <= 2'b00;
      rsp_rdata  <= 8'h00;
      uio_out    <= 8'h00;
      uio_oe     <= OE_NONE;
      busy       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      req_ready <= 2'b00;
      rsp_valid <= 2'b00;
      unique case (state_q)
        IDLE: begin
          // Pads keep their last level here: write direction holds FF and the last byte.
          if (ena && pick_any) begin
            gnt_q      <= pick_idx;
            wr_q       <= pick_wr;
            byte_q     <= pick_byte;
            last_grant <= pick_idx;
            busy       <= 1'b1;
            if (pick_wr != dir_q) begin
              state_q <= TURN;
              cnt_q   <= TurnLast;
              uio_oe  <= OE_NONE;
              uio_out <= 8'h00;
            end else begin
              state_q <= XFER;
              cnt_q   <= HoldLast;
              uio_oe  <= pick_wr ? OE_ALL : OE_NONE;
              uio_out <= pick_wr ? pick_byte : 8'h00;
              if (HoldOne) req_ready[pick_idx] <= 1'b1;
            end
          end
        end
        TURN: begin
          if (cnt_q == '0) begin
            state_q <= XFER;
            dir_q   <= wr_q;
            cnt_q   <= HoldLast;
            uio_oe  <= wr_q ? OE_ALL : OE_NONE;
            uio_out <= wr_q ? byte_q : 8'h00;
            if (HoldOne) req_ready[gnt_q] <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        XFER: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            if (wr_q == DIR_IN) begin
              rsp_rdata        <= uio_in;
              rsp_valid[gnt_q] <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
            // Entering the final hold cycle: ready must be visible during it.
            if (cnt_q == CntOne) req_ready[gnt_q] <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uio_bus_arbiter.md
# uio_bus_arbiter

Shares the 8-bit bidirectional `uio` pad bus of the `tt_um_*` top between two internal requesters. Each requester asks for a write (drive a byte onto the pins) or a read (sample a byte from the pins). The block picks requesters round-robin, owns `uio_out`/`uio_oe`, and inserts a bus-turnaround gap whenever pin direction changes. It sits directly under the top-level module, between the user logic and the `uio_*` ports.

## Interface
- `HOLD_CYCLES`, 2, cycles each transfer occupies the pins (≥1)
- `TURN_CYCLES`, 1, idle cycles with `uio_oe=8'h00` on a direction change (≥1)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `ena`  in  1  design enable; low blocks new grants, in-flight transfer completes
- `req_valid`  in  2  per-requester request
- `req_write`  in  2  per-requester: 1 = write (drive), 0 = read (sample)
- `req_wdata`  in  16  write bytes; [7:0] requester 0, [15:8] requester 1
- `req_ready`  out  2  one-cycle accept/complete pulse per requester
- `rsp_valid`  out  2  one-cycle read-data pulse per requester
- `rsp_rdata`  out  8  last sampled read byte
- `uio_in`  in  8  pad input
- `uio_out`  out  8  pad output
- `uio_oe`  out  8  pad enable, all bits equal: 8'hFF drive, 8'h00 input
- `busy`  out  1  high in TURN or XFER
- `last_grant`  out  1  index of most recently granted requester

## Operation
- States: IDLE, TURN, XFER. Counter `cnt` is sized for max(HOLD_CYCLES, TURN_CYCLES).
- IDLE:
  - If `ena` and any `req_valid`, grant one requester.
  - If both are valid, grant `~last_grant`; otherwise grant the valid one.
  - On grant, latch index, `req_write` and the wdata byte, and update `last_grant`.
  - If latched direction ≠ current bus direction `dir_q`, go to TURN; otherwise go to XFER.
- TURN: `uio_oe=00`, `uio_out=00` for TURN_CYCLES. Then set `dir_q` to the new direction and go to XFER.
- XFER write: `uio_oe=FF`, `uio_out`=latched byte for HOLD_CYCLES.
- XFER read: `uio_oe=00` for HOLD_CYCLES.
- Last XFER cycle: `req_ready[g]=1`, then return to IDLE.
- Read completion: `rsp_rdata` takes `uio_in` at the clock edge ending the last XFER cycle. `rsp_valid[g]` pulses in the following cycle. `rsp_rdata` holds until the next read.
- IDLE drive: `uio_oe` stays per `dir_q` (write direction keeps FF with the last byte, so a bus-keeper level is held). Write-to-write transfers therefore need no turnaround.
- Requesters hold `valid` and their attributes until `ready`. Attributes are latched at grant, so dropping `valid` early still completes the latched transfer.
- `ena` falling during TURN or XFER: the transfer completes and no new grant is made.
- A request whose `valid` rises during a transfer waits for the next IDLE.

## Timing
- All outputs are registered.
- Reset values (asynchronous, effective while `rst_n=0`):
  - `uio_oe=00`, `uio_out=00`
  - `req_ready=0`, `rsp_valid=0`, `rsp_rdata=00`
  - `busy=0`, `last_grant=1`
  - state IDLE, `dir_q`=input
- Grant decision in IDLE cycle t. XFER starts at t+1, or TURN occupies t+1..t+TURN_CYCLES.
- Write latency with no turn: pins driven t+1..t+HOLD_CYCLES, `req_ready` in cycle t+HOLD_CYCLES, IDLE again at t+HOLD_CYCLES+1.
- Throughput: one transfer per HOLD_CYCLES+1 cycles, plus TURN_CYCLES on each direction change.
- Reset mid-transfer: the transfer is aborted and all outputs take their reset values immediately. No `ready` or `rsp_valid` is emitted for the aborted transfer.

## Structure
- Package `uio_arb_pkg`:
  - state enum `{IDLE, TURN, XFER}`
  - `DIR_IN=1'b0`, `DIR_OUT=1'b1`
  - `OE_ALL=8'hFF`, `OE_NONE=8'h00`
- Sub-module `rr_arb2`: combinational 2-way round-robin picker. Inputs are `valid[1:0]` and `last`; outputs are `gnt_idx` and `gnt_any`.
- FSM, counter and pad registers live in `uio_bus_arbiter`.

## Test plan
All scenarios use default parameters.
1. Hold `rst_n=0`, with `req_valid=11` -> `uio_oe=00`, `uio_out=00`, `busy=0`, `req_ready=00`.
2. Release reset; req0 writes A5 -> 1 TURN cycle with `oe=00`, then `oe=FF` and `out=A5` for 2 cycles. `req_ready[0]` pulses in the 2nd XFER cycle.
3. Then req1 reads with `uio_in=3C` -> 1 TURN cycle with `oe=00`, 2 XFER cycles with `oe=00`, `req_ready[1]` pulse, then next cycle `rsp_valid[1]=1` and `rsp_rdata=3C`.
4. From reset, both request writes (11, 22) simultaneously -> req0 is granted first. `out=11` then `out=22`, separated by one IDLE cycle, with no TURN between them. `last_grant` ends at 1.
5. `ena=0` with `req_valid=01` for 5 cycles -> `busy=0` and no grant. Raising `ena` -> grant in that IDLE cycle.
6. Assert `rst_n=0` during the first XFER cycle of a write -> `uio_oe` goes to 00 asynchronously and no `req_ready`. After release, a new req1 write is granted (`last_grant` reset to 1, so a lone req1 still wins).
